// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: matrix geometry, key_code field layout, FSM states
// and the row priority encoder.
package keypad_scanner_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  typedef logic [1:0] state_t;

  localparam state_t SCAN       = 2'd0;
  localparam state_t PRESS_DB   = 2'd1;
  localparam state_t HOLD       = 2'd2;
  localparam state_t RELEASE_DB = 2'd3;

  // Lowest-numbered low row wins; caller guarantees at least one bit is low.
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all ones so
// idle pulled-up lines read inactive.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces press and
// release on the latched row, and emits one key_valid strobe per keystroke.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CNT - 1);

  logic [ROWS-1:0]  rows_s;
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             row_bit;

  sync_2ff #(.WIDTH(ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (rows_s)
  );

  assign row_bit = rows_s[row_q];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (dwell_q >= DWELL_LAST) begin
          dwell_d = '0;
          if (rows_s != {ROWS{1'b1}}) begin
            row_d   = low_row(rows_s);
            db_d    = '0;
            state_d = PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      PRESS_DB: begin
        if (row_bit) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (db_q >= DB_LAST) begin
          key_valid_d                  = 1'b1;
          key_code_d[ROW_MSB:ROW_LSB]  = row_q;
          key_code_d[COL_MSB:COL_LSB]  = col_q;
          state_d                      = HOLD;
        end else begin
          db_d = db_q + 1'b1;
        end
      end

      HOLD: begin
        if (row_bit) begin
          db_d    = '0;
          state_d = RELEASE_DB;
        end
      end

      RELEASE_DB: begin
        // A low reading here is contact bounce on the same key, not a new press.
        if (!row_bit) begin
          state_d = HOLD;
        end else if (db_q >= DB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      db_q        <= '0;
      key_code_q  <= 4'b0000;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
    assign col_out[gi] = (col_q != 2'(gi));
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix and a
// per-cycle checker of the strobe/key_code/column-drive rules.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;

  logic [15:0] pressed = '0;   // index r*4+c
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic [3:0]  exp_code = 4'h0;
  logic [3:0]  prev_code = 4'h0;
  logic        prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Every cycle: one-hot-low columns, single-cycle strobes carrying the
  // expected key, key_code steady between strobes, reset values under reset.
  always @(negedge clk) begin
    chk("col_onehot", $countones(~col_out), 1);
    if (!rst_n) begin
      chk("rst_valid", key_valid, 0);
      chk("rst_code", key_code, 4'h0);
      chk("rst_col", col_out, 4'hE);
      prev_code  = 4'h0;
      prev_valid = 1'b0;
    end else begin
      if (key_valid) begin
        pulses++;
        chk("strobe_code", key_code, exp_code);
        chk("strobe_single", prev_valid, 0);
        prev_code = exp_code;
      end else begin
        chk("code_hold", key_code, prev_code);
      end
      prev_valid = key_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int maxc, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < maxc) begin
      @(negedge clk);
      lat++;
      if (key_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_col_enter(input logic [3:0] target, input int maxc, output bit seen);
    logic [3:0] prev;
    int         n;
    prev = col_out;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < maxc) begin
      @(negedge clk);
      n++;
      if (col_out == target && prev != target) seen = 1'b1;
      prev = col_out;
    end
  endtask

  task automatic wait_col_leave(input logic [3:0] from, input int maxc,
                                output bit seen, output logic [3:0] val);
    int n;
    seen = 1'b0;
    val  = from;
    n    = 0;
    while (!seen && n < maxc) begin
      @(negedge clk);
      n++;
      if (col_out != from) begin
        seen = 1'b1;
        val  = col_out;
      end
    end
  endtask

  initial begin
    int         lat;
    bit         seen;
    int         p0;
    int         run;
    logic [3:0] val;
    logic [3:0] seq [4];
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_col", col_out, 4'b1110);
    chk("reset_code", key_code, 4'b0000);
    chk("reset_valid", key_valid, 0);
    rst_n = 1'b1;
    tick(5);

    // (1,1) held 200 cycles: one strobe within the latency bound
    p0 = pulses;
    exp_code = 4'b0101;
    pressed[1*4+1] = 1'b1;
    wait_pulse(40, lat, seen);
    total++;
    if (!seen || lat > 27) begin
      bad++;
      $display("FAIL t1_latency: got seen=%0d lat=%0d expected seen=1 lat<=27", seen, lat);
    end
    chk("t1_code", key_code, 4'b0101);
    $display("t1 press (1,1): latency=%0d code=%b", lat, key_code);
    tick(200 - lat);
    pressed = '0;
    tick(40);
    chk("t1_pulses", pulses - p0, 1);

    // (2,0) bounce of 5 cycles: no strobe, scanning continues in order
    p0 = pulses;
    pressed[2*4+0] = 1'b1;
    tick(5);
    pressed = '0;
    tick(60);
    chk("t2_no_pulse", pulses - p0, 0);
    wait_col_enter(4'b1110, 40, seen);
    chk("t2_col_found", seen, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (SD) @(negedge clk);
      chk("t2_col_seq", col_out, seq[k]);
    end
    $display("t2 bounce (2,0): pulses=%0d", pulses - p0);

    // (3,3) held, released, pressed again: two strobes
    p0 = pulses;
    exp_code = 4'b1111;
    pressed[3*4+3] = 1'b1;
    tick(1000);
    pressed = '0;
    tick(50);
    pressed[3*4+3] = 1'b1;
    tick(100);
    pressed = '0;
    tick(40);
    chk("t3_pulses", pulses - p0, 2);
    $display("t3 double press (3,3): pulses=%0d", pulses - p0);

    // (0,2) and (3,2) together: row 0 wins, nothing for row 3
    p0 = pulses;
    exp_code = 4'b0010;
    pressed[0*4+2] = 1'b1;
    pressed[3*4+2] = 1'b1;
    wait_pulse(40, lat, seen);
    chk("t4_seen", seen, 1);
    chk("t4_code", key_code, 4'b0010);
    tick(150);
    pressed = '0;
    tick(40);
    chk("t4_pulses", pulses - p0, 1);
    $display("t4 priority (0,2)+(3,2): pulses=%0d", pulses - p0);

    // (1,3) with bounce during release debounce
    p0 = pulses;
    exp_code = 4'b0111;
    pressed[1*4+3] = 1'b1;
    wait_pulse(40, lat, seen);
    chk("t5_seen", seen, 1);
    chk("t5_code", key_code, 4'b0111);
    tick(10);
    pressed[1*4+3] = 1'b0;
    tick(3);
    pressed[1*4+3] = 1'b1;
    tick(3);
    pressed[1*4+3] = 1'b0;
    wait_col_leave(4'b0111, 40, seen, val);
    chk("t5_col_leave", seen, 1);
    chk("t5_col_next", val, 4'b1110);
    tick(20);
    chk("t5_pulses", pulses - p0, 1);
    $display("t5 release bounce (1,3): pulses=%0d next_col=%b", pulses - p0, val);

    // (2,1): reset during press debounce cancels the event
    p0 = pulses;
    pressed[2*4+1] = 1'b1;
    run  = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (col_out == 4'b1101) run++;
      else run = 0;
      if (run == SD + 2) seen = 1'b1;
    end
    chk("t6_in_press_db", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_col", col_out, 4'b1110);
    chk("t6_rst_code", key_code, 4'b0000);
    chk("t6_rst_valid", key_valid, 0);
    pressed = '0;
    tick(3);
    rst_n = 1'b1;
    tick(60);
    chk("t6_no_pulse", pulses - p0, 0);
    chk("t6_code_after", key_code, 4'b0000);
    $display("t6 reset mid-debounce (2,1): pulses=%0d code=%b", pulses - p0, key_code);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
